// File: rtl/shift_cnt_mix_pkg.sv
// Shared constants for the shift/count/mix datapath: counter modes and legal width range.
package shift_cnt_mix_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int W_MIN = 2;
  localparam int W_MAX = 16;

  function automatic bit width_ok(input int w);
    return (w >= W_MIN) && (w <= W_MAX);
  endfunction

endpackage

// File: rtl/shift_reg_n.sv
// W-bit serial-in shift register, newest bit enters at the LSB; 1-cycle latency, no backpressure.
module shift_reg_n #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= {dout[W-2:0], din};
    end
  end

endmodule

// File: rtl/shift_cnt_mix_n.sv
// Shifter + up/down counter with XOR mix, delayed-select invert and channel swap.
// Outputs are 0-cycle from registers (do2 one cycle later); co1/co2 are combinational; no backpressure.
module shift_cnt_mix_n
  import shift_cnt_mix_pkg::*;
#(
  parameter int W        = 4,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         din,
  input  logic         shift_en,
  input  logic         up1_dn0,
  input  logic         cnt_en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         sel,
  input  logic         cin1,
  input  logic         cin2,
  output logic [W-1:0] do1,
  output logic [W-1:0] do2,
  output logic [W-1:0] do3,
  output logic         co1,
  output logic         co2,
  output logic         cnt_max,
  output logic         cnt_min
);

  if (!width_ok(W)) begin : g_bad_width
    $error("shift_cnt_mix_n: W out of range 2..16");
  end
  if ((SAT_MODE != MODE_WRAP) && (SAT_MODE != MODE_SAT)) begin : g_bad_mode
    $error("shift_cnt_mix_n: SAT_MODE must be 0 or 1");
  end

  localparam logic [W-1:0] CNT_TOP = '1;
  localparam bit           SAT     = (SAT_MODE == MODE_SAT);

  logic [W-1:0] shreg;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] xor_ff;
  logic         sel_d1;
  logic         din_inv;

  assign din_inv = ~din;

  shift_reg_n #(
    .W(W)
  ) u_shift_reg (
    .clk  (clk),
    .n_rst(n_rst),
    .en   (shift_en),
    .din  (din_inv),
    .dout (shreg)
  );

  // load beats counting; saturate mode pins the count at either end
  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (cnt_en) begin
      if (up1_dn0) begin
        if (!(SAT && (cnt == CNT_TOP))) begin
          cnt_nxt = cnt + W'(1);
        end
      end else begin
        if (!(SAT && (cnt == '0))) begin
          cnt_nxt = cnt - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt    <= '0;
      xor_ff <= '0;
      sel_d1 <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      xor_ff <= do1;
      sel_d1 <= sel;
    end
  end

  assign do1     = shreg ^ cnt;
  assign do2     = xor_ff;
  assign do3     = sel_d1 ? ~cnt : cnt;
  assign cnt_max = (cnt == CNT_TOP);
  assign cnt_min = (cnt == '0);

  assign co1 = sel ? cin2 : cin1;
  assign co2 = sel ? cin1 : cin2;

endmodule

// File: tb/tb_shift_cnt_mix_n.sv
// Bench for shift_cnt_mix_n at W=4: wrap and saturate instances side by side against a behavioural model.
module tb_shift_cnt_mix_n;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic n_rst, din, shift_en, up1_dn0, cnt_en, load, sel, cin1, cin2;
  logic [W-1:0] load_val;

  logic [W-1:0] do1_w, do2_w, do3_w, do1_s, do2_s, do3_s;
  logic co1_w, co2_w, cmax_w, cmin_w, co1_s, co2_s, cmax_s, cmin_s;

  int checks   = 0;
  int failures = 0;

  // model state: shifter and sel delay are shared, counter/xor per mode (0 wrap, 1 sat)
  int m_shreg;
  int m_seld;
  int m_cnt[2];
  int m_xor[2];

  always #5 clk = ~clk;

  shift_cnt_mix_n #(.W(W), .SAT_MODE(0)) dut_w (
    .clk(clk), .n_rst(n_rst), .din(din), .shift_en(shift_en), .up1_dn0(up1_dn0),
    .cnt_en(cnt_en), .load(load), .load_val(load_val), .sel(sel), .cin1(cin1), .cin2(cin2),
    .do1(do1_w), .do2(do2_w), .do3(do3_w), .co1(co1_w), .co2(co2_w),
    .cnt_max(cmax_w), .cnt_min(cmin_w)
  );

  shift_cnt_mix_n #(.W(W), .SAT_MODE(1)) dut_s (
    .clk(clk), .n_rst(n_rst), .din(din), .shift_en(shift_en), .up1_dn0(up1_dn0),
    .cnt_en(cnt_en), .load(load), .load_val(load_val), .sel(sel), .cin1(cin1), .cin2(cin2),
    .do1(do1_s), .do2(do2_s), .do3(do3_s), .co1(co1_s), .co2(co2_s),
    .cnt_max(cmax_s), .cnt_min(cmin_s)
  );

  typedef struct {
    logic       sh_en;
    logic       din;
    logic       cnt_en;
    logic       up;
    logic       load;
    logic [3:0] lval;
    logic [3:0] exp_shreg;
    logic [3:0] exp_cw;
    logic [3:0] exp_cs;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic sh_en, input logic d, input logic ce, input logic up,
                              input logic ld, input logic [3:0] lv, input logic [3:0] es,
                              input logic [3:0] ew, input logic [3:0] esat);
    vec_t v;
    v.sh_en = sh_en; v.din = d; v.cnt_en = ce; v.up = up; v.load = ld; v.lval = lv;
    v.exp_shreg = es; v.exp_cw = ew; v.exp_cs = esat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shreg = 0;
    m_seld  = 0;
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0;
      m_xor[m] = 0;
    end
  endtask

  task automatic model_step();
    if (n_rst !== 1'b1) return;
    for (int m = 0; m < 2; m++) begin
      m_xor[m] = m_shreg ^ m_cnt[m];
      if (load) begin
        m_cnt[m] = int'(load_val);
      end else if (cnt_en && up1_dn0) begin
        m_cnt[m] = (m == 1) ? ((m_cnt[m] == MAXV) ? MAXV : m_cnt[m] + 1) : (m_cnt[m] + 1) % (MAXV + 1);
      end else if (cnt_en) begin
        m_cnt[m] = (m == 1) ? ((m_cnt[m] == 0) ? 0 : m_cnt[m] - 1) : (m_cnt[m] + MAXV) % (MAXV + 1);
      end
    end
    m_seld = int'(sel);
    if (shift_en) m_shreg = ((m_shreg * 2) + (din ? 0 : 1)) % (MAXV + 1);
  endtask

  task automatic check_all(input string tag);
    int exp_co1, exp_co2;
    exp_co1 = sel ? int'(cin2) : int'(cin1);
    exp_co2 = sel ? int'(cin1) : int'(cin2);
    chk({tag, "_do1_w"}, 32'(do1_w), 32'(m_shreg ^ m_cnt[0]));
    chk({tag, "_do2_w"}, 32'(do2_w), 32'(m_xor[0]));
    chk({tag, "_do3_w"}, 32'(do3_w), 32'(m_seld ? (MAXV - m_cnt[0]) : m_cnt[0]));
    chk({tag, "_cmax_w"}, 32'(cmax_w), 32'(m_cnt[0] == MAXV));
    chk({tag, "_cmin_w"}, 32'(cmin_w), 32'(m_cnt[0] == 0));
    chk({tag, "_do1_s"}, 32'(do1_s), 32'(m_shreg ^ m_cnt[1]));
    chk({tag, "_do2_s"}, 32'(do2_s), 32'(m_xor[1]));
    chk({tag, "_do3_s"}, 32'(do3_s), 32'(m_seld ? (MAXV - m_cnt[1]) : m_cnt[1]));
    chk({tag, "_cmax_s"}, 32'(cmax_s), 32'(m_cnt[1] == MAXV));
    chk({tag, "_cmin_s"}, 32'(cmin_s), 32'(m_cnt[1] == 0));
    chk({tag, "_co1"}, 32'(co1_w), 32'(exp_co1));
    chk({tag, "_co2"}, 32'(co2_w), 32'(exp_co2));
    chk({tag, "_co1_s"}, 32'(co1_s), 32'(exp_co1));
    chk({tag, "_co2_s"}, 32'(co2_s), 32'(exp_co2));
  endtask

  // one rising edge, model follows it, outputs sampled 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    n_rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    n_rst = 1'b1;
  endtask

  task automatic set_in(input logic se, input logic d, input logic ce, input logic up,
                        input logic ld, input logic [3:0] lv);
    shift_en = se; din = d; cnt_en = ce; up1_dn0 = up; load = ld; load_val = lv;
  endtask

  initial begin
    n_rst = 1'b0;
    sel = 1'b0; cin1 = 1'b1; cin2 = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    model_reset();
    #2;
    check_all("rst");
    chk("rst_co1_follows", 32'(co1_w), 32'd1);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    n_rst = 1'b1;

    vt[0]  = mk(1, 0, 0, 0, 0, 4'h0, 4'b0001, 4'h0, 4'h0);
    vt[1]  = mk(1, 1, 0, 0, 0, 4'h0, 4'b0010, 4'h0, 4'h0);
    vt[2]  = mk(1, 1, 0, 0, 0, 4'h0, 4'b0100, 4'h0, 4'h0);
    vt[3]  = mk(1, 0, 0, 0, 0, 4'h0, 4'b1001, 4'h0, 4'h0);
    vt[4]  = mk(0, 0, 0, 0, 1, 4'hE, 4'b1001, 4'hE, 4'hE);
    vt[5]  = mk(0, 0, 1, 1, 0, 4'h0, 4'b1001, 4'hF, 4'hF);
    vt[6]  = mk(0, 0, 1, 1, 0, 4'h0, 4'b1001, 4'h0, 4'hF);
    vt[7]  = mk(0, 0, 1, 1, 0, 4'h0, 4'b1001, 4'h1, 4'hF);
    vt[8]  = mk(0, 0, 1, 0, 0, 4'h0, 4'b1001, 4'h0, 4'hE);
    vt[9]  = mk(0, 0, 1, 0, 0, 4'h0, 4'b1001, 4'hF, 4'hD);
    vt[10] = mk(0, 0, 0, 0, 1, 4'h1, 4'b1001, 4'h1, 4'h1);
    vt[11] = mk(0, 0, 1, 0, 0, 4'h0, 4'b1001, 4'h0, 4'h0);
    vt[12] = mk(0, 0, 1, 0, 0, 4'h0, 4'b1001, 4'hF, 4'h0);
    vt[13] = mk(0, 0, 1, 0, 0, 4'h0, 4'b1001, 4'hE, 4'h0);
    vt[14] = mk(0, 0, 1, 1, 1, 4'h3, 4'b1001, 4'h3, 4'h3);
    for (int i = 15; i < 20; i++) vt[i] = mk(0, 0, 0, 1, 0, 4'h0, 4'b1001, 4'h3, 4'h3);

    for (int i = 0; i < 20; i++) begin
      set_in(vt[i].sh_en, vt[i].din, vt[i].cnt_en, vt[i].up, vt[i].load, vt[i].lval);
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_do1_w", i), 32'(do1_w), 32'(vt[i].exp_shreg ^ vt[i].exp_cw));
      chk($sformatf("tbl%0d_do1_s", i), 32'(do1_s), 32'(vt[i].exp_shreg ^ vt[i].exp_cs));
      chk($sformatf("tbl%0d_do3_w", i), 32'(do3_w), 32'(vt[i].exp_cw));
      chk($sformatf("tbl%0d_do3_s", i), 32'(do3_s), 32'(vt[i].exp_cs));
      chk($sformatf("tbl%0d_cmax_w", i), 32'(cmax_w), 32'(vt[i].exp_cw == 4'hF));
      chk($sformatf("tbl%0d_cmin_s", i), 32'(cmin_s), 32'(vt[i].exp_cs == 4'h0));
    end

    // build cnt=9, shreg=0101, then reset while counting
    set_in(1, 1, 0, 0, 1, 4'h9);
    tick("pre_rst0");
    set_in(1, 0, 0, 0, 0, 4'h0);
    tick("pre_rst1");
    set_in(1, 1, 0, 0, 0, 4'h0);
    tick("pre_rst2");
    set_in(1, 0, 0, 0, 0, 4'h0);
    tick("pre_rst3");
    chk("pre_rst_do1", 32'(do1_w), 32'h5 ^ 32'h9);
    set_in(1, 1, 1, 1, 0, 4'h0);
    tick("mid_count");
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_do1", 32'(do1_w), 32'h0);
    chk("midrst_do2", 32'(do2_w), 32'h0);
    chk("midrst_do3", 32'(do3_w), 32'h0);
    chk("midrst_cmin", 32'(cmin_w), 32'h1);
    chk("midrst_cmax", 32'(cmax_w), 32'h0);
    check_all("midrst");
    n_rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 4'h0);
    tick("post_rst");

    // invert/swap: sel rises mid-cycle, co swaps at once, do3 inverts after the edge
    set_in(0, 0, 0, 0, 1, 4'h6);
    tick("inv_load");
    load = 1'b0;
    cin1 = 1'b1; cin2 = 1'b0; sel = 1'b1;
    #1;
    chk("swap_co1", 32'(co1_w), 32'h0);
    chk("swap_co2", 32'(co2_w), 32'h1);
    chk("inv_before", 32'(do3_w), 32'h6);
    tick("inv_edge");
    chk("inv_after", 32'(do3_w), 32'h9);
    chk("inv_after_s", 32'(do3_s), 32'h9);

    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
             1'($urandom_range(0, 11) == 0), 4'($urandom));
      sel  = 1'($urandom);
      cin1 = 1'($urandom);
      cin2 = 1'($urandom);
      if ($urandom_range(0, 49) == 0) async_reset_pulse($sformatf("rnd_rst%0d", i));
      tick($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_cnt_mix_n.md
# shift_cnt_mix_n

Parametrised successor to the fixed 2-bit shift/count/mix datapath. It contains:
- a W-bit serial-in shifter fed with inverted serial data;
- a W-bit up/down counter with load, enable and wrap or saturate mode;
- a combinational and a registered XOR mix of the two;
- a select-delayed invert path and a two-channel swap.

It sits in the same front-end test datapath as a drop-in, wider, controllable replacement for the 2-bit block.

## Interface
- W, 4: datapath width for shifter, counter and all W-bit outputs; legal range 2..16.
- SAT_MODE, 0: 0 = counter wraps modulo 2^W; 1 = counter saturates at 0 and 2^W-1.

Clock is `clk`. Reset is `n_rst`, asynchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- din  in  1  serial data; inverted before entering shifter
- shift_en  in  1  shifter advances when 1
- up1_dn0  in  1  count direction: 1 = up, 0 = down
- cnt_en  in  1  counter steps when 1
- load  in  1  synchronous counter load, priority over cnt_en
- load_val  in  W  counter load value
- sel  in  1  invert select for do3 (registered internally) and swap select
- cin1, cin2  in  1 each  swap inputs
- do1  out  W  combinational shreg ^ cnt
- do2  out  W  registered do1
- do3  out  W  sel_d1 ? ~cnt : cnt
- co1, co2  out  1 each  sel ? cin2 : cin1, sel ? cin1 : cin2
- cnt_max  out  1  cnt == 2^W-1
- cnt_min  out  1  cnt == 0

## Operation
- Shifter: shreg <= {shreg[W-2:0], ~din} when shift_en. It holds otherwise. The newest bit is the LSB.
- Counter priority, evaluated per edge:
  1. load: cnt <= load_val.
  2. else cnt_en && up1_dn0: increment.
  3. else cnt_en && !up1_dn0: decrement.
  4. else hold.
- Wrap mode (SAT_MODE=0):
  - 2^W-1 + 1 -> 0.
  - 0 - 1 -> 2^W-1.
  - Arithmetic is unsigned and truncated to W bits.
- Saturate mode (SAT_MODE=1):
  - Increment at 2^W-1 holds at 2^W-1.
  - Decrement at 0 holds at 0.
- XOR mix: do1 = shreg ^ cnt, combinational from registers only, with no input feed-through. xor_ff <= do1 every cycle, and do2 = xor_ff.
- Invert path: sel_d1 <= sel every cycle. do3 = sel_d1 ? ~cnt : cnt.
- Swap path: co1 and co2 are purely combinational from sel, cin1 and cin2. This is the only input-to-output combinational path.
- cnt_max and cnt_min are decoded combinationally from cnt.
- Reset values:
  - shreg, cnt, xor_ff and sel_d1 reset to 0.
  - Hence do1, do2 and do3 are 0, cnt_min = 1 and cnt_max = 0.
  - co1 and co2 follow inputs even during reset.
- Reset mid-operation: all registers clear asynchronously on n_rst fall. No partial shift or count completes. The first update after release occurs on the first rising edge with n_rst = 1.

## Timing
- shreg and cnt update on edge N. do1, do3 (cnt part), cnt_max and cnt_min reflect the change after edge N, with 0-cycle latency from the register.
- do2 lags do1 by exactly 1 cycle.
- A sel change before edge N affects:
  - co1 and co2 immediately (combinational);
  - do3 inversion from after edge N (1-cycle lag).
- A load_val applied with load before edge N appears on cnt, do1 and do3 after edge N. It appears on do2 after edge N+1.
- Serial din bit sampled at edge N reaches shreg[k] after edge N+k, provided shift_en is held high.
- There is no handshake. All inputs are sampled every cycle and must meet setup to clk.

## Structure
- Shared package `shift_cnt_mix_pkg` contains:
  - mode constants MODE_WRAP = 0 and MODE_SAT = 1;
  - a width-range check constant.
  - The top-level asserts that W is within 2..16 at elaboration.
- The shifter is one natural sub-module, `shift_reg_n`, with parameter W and ports clk, n_rst, en, din, dout[W-1:0].
- The inversion of din is done in the parent, not in `shift_reg_n`.
- Counter, XOR register, sel_d1 register and swap stay in the top-level.

## Test plan
- Reset check, W=4: assert n_rst=0 mid-count with cnt=4'h9 and shreg=4'h5 → do1=do2=do3=0, cnt_min=1 immediately, without waiting for a clock edge.
- Shifter, W=4, shift_en=1: din=0,1,1,0 over 4 edges → shreg=4'b1001. do2 equals the previous cycle's do1 on every cycle.
- Wrap mode: load 4'hE, then up ×3 → cnt = F, 0, 1. cnt_max=1 only at F. Then down ×2 → 0, F.
- Saturate mode: load 4'hE, then up ×3 → cnt = F, F, F. Then load 4'h1 and down ×3 → 0, 0, 0 with cnt_min=1.
- Priority: load=1 and cnt_en=1 with up1_dn0=1 and load_val=4'h3 → cnt=3, not 4. cnt_en=0 → cnt holds across 5 edges.
- Invert/swap: cnt=4'h6, raise sel before edge N → co1=cin2 and co2=cin1 immediately; do3=4'h6 until edge N, then 4'h9.
